c13_mac_sequencer: RTL
======================

Name: c13_mac_sequencer

Overview:
- Registered operand-feed and accumulate stage wrapped around the combinational 4x4 array multiplier.
- Upstream: accepts packed operand bytes over a valid/ready handshake and drives the multiplier's operand byte.
- Downstream: captures the multiplier's 8-bit product, accumulates N_TERMS products into a sum-of-products, and presents the result over a valid/ready handshake.

Parameters:
- ACC_W, 16, accumulator width in bits; must be >= 8.
- N_TERMS, 4, products per frame; must be >= 1. The term counter width is clog2(N_TERMS), minimum 1.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand byte valid.
- in_ready  output  1  block can accept an operand byte.
- in_data  input  8  operand pair: m = [7:4], q = [3:0], both unsigned.
- mul_op  output  8  registered operand byte to the multiplier, same packing as in_data.
- mul_prod  input  8  unsigned product m*q returned combinationally by the multiplier.
- out_valid  output  1  accumulated result valid.
- out_ready  input  1  consumer accepts the result.
- out_acc  output  ACC_W  sum of N_TERMS products, modulo 2^ACC_W.
- out_ovf  output  1  sticky: the frame sum exceeded 2^ACC_W-1.
- busy  output  1  high whenever the state is not ACCEPT or the term count is nonzero.

Behaviour:
- Interface: single clock clk; reset rst is synchronous and active-high.
- Reset values:
  - state = ACCEPT; mul_op = 0x00; acc = 0; cnt = 0; ovf = 0.
  - out_valid = 0; in_ready = 0 during any cycle with rst high.
- FSM states: ACCEPT, MUL, DONE.
- ACCEPT:
  - in_ready = 1.
  - On in_valid & in_ready: mul_op <= in_data; next state MUL.
  - Otherwise hold; mul_op keeps its last value.
- MUL (exactly one cycle):
  - in_ready = 0; mul_op is stable so mul_prod settles within the cycle.
  - At the edge: acc <= acc + zero-extended mul_prod, truncated to ACC_W bits.
  - ovf <= ovf | carry-out of that add.
  - cnt <= cnt + 1.
  - Next state DONE if cnt == N_TERMS-1, else ACCEPT.
- DONE:
  - out_valid = 1; in_ready = 0; out_acc = acc; out_ovf = ovf.
  - out_acc and out_ovf stay stable while out_valid=1 and out_ready=0.
  - On out_ready: acc <= 0, cnt <= 0, ovf <= 0; next state ACCEPT.
- Outside DONE: out_valid = 0. out_acc and out_ovf show running acc and ovf; consumers ignore them.
- in_valid is ignored while in_ready = 0; no data is captured or lost-counted.
- Throughput: at most one term per 2 cycles.
- Latency: the final term handshake at edge k gives out_valid high in the cycle after edge k+1. The earliest next frame accept is the cycle after the out handshake edge.
- in_data changing while in MUL or DONE has no effect. mul_prod is sampled only in MUL.
- rst asserted in any state, including mid-frame or in DONE with out_ready low, discards the partial sum and returns to the reset values on the next edge.
- N_TERMS = 1: every accepted term yields a result; the state sequence is ACCEPT -> MUL -> DONE.

Test Plan:
- Reset: hold rst high 2 cycles, with in_valid=1 throughout -> in_ready=0, out_valid=0, mul_op=0x00, out_acc=0, busy=0. The first cycle after rst low gives in_ready=1.
- Basic frame (defaults, multiplier model = m*q): bytes 0x35, 0xFF, 0x09, 0x72 back-to-back.
  - Products are 15, 225, 0, 14.
  - Expect out_acc=254, out_ovf=0.
  - out_valid rises one cycle after the 4th MUL cycle.
  - mul_op equals each byte during its MUL cycle.
- Backpressure: same frame, out_ready low 5 cycles after out_valid, in_valid pulsed during the stall.
  - out_valid, out_acc=254 held; in_ready=0; the stall pulses are not captured.
  - After the handshake, bytes 0x11 x4 -> out_acc=4.
- Bubbles: frame 0xF1, 0x2F, 0x33, 0x44 with 0-3 random idle cycles between in_valid pulses -> out_acc = 15+30+9+16 = 70, identical to the back-to-back run.
- Overflow (ACC_W=8, N_TERMS=2): 0xFF, 0xFF -> out_acc = 450 mod 256 = 194, out_ovf=1. Next frame 0x22, 0x11 -> out_acc=5, out_ovf=0.
- Mid-frame reset (defaults): accept 0xFF, 0xFF, pulse rst 1 cycle, then send 0x23, 0x45, 0x12, 0x01 -> out_acc = 6+20+2+0 = 28. No out_valid occurs before the 4th post-reset term.

Source files
------------

// File: rtl/c13_mac_sequencer_if.sv
// Handshake bundle for c13_mac_sequencer.
//   Upstream   : in_valid / in_ready / in_data (m = [7:4], q = [3:0])
//   Downstream : out_valid / out_ready / out_acc / out_ovf
// slave  : the sequencer's view (consumes operands, produces results)
// master : the environment's view (produces operands, consumes results)
interface c13_mac_sequencer_if #(
  parameter int ACC_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_data;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_acc;
  logic             out_ovf;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_acc, out_ovf
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_acc, out_ovf
  );
endinterface

// File: rtl/c13_mac_sequencer.sv
// c13_mac_sequencer: registered operand feed and sum-of-products accumulator
// around an external combinational 4x4 multiplier.
//   clk, rst  : clock, synchronous active-high reset
//   bus       : operand input and result output handshakes (slave modport)
//   mul_op    : registered operand byte driven to the multiplier
//   mul_prod  : unsigned product m*q returned by the multiplier
//   busy      : high when not idle in ACCEPT with an empty frame
// One operand byte is taken per ACCEPT->MUL pass; after N_TERMS products
// the sum is held in DONE until the consumer takes it.
module c13_mac_sequencer #(
  parameter int ACC_W   = 16,
  parameter int N_TERMS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  c13_mac_sequencer_if.slave    bus,
  output logic [7:0]            mul_op,
  input  logic [7:0]            mul_prod,
  output logic                  busy
);

  localparam int CNT_W = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;
  localparam logic [CNT_W-1:0] LAST_TERM = CNT_W'(N_TERMS - 1);

  typedef enum logic [1:0] {ACCEPT, MUL, DONE} state_t;

  state_t           state, state_nxt;
  logic             in_rdy, out_vld;
  logic [7:0]       mul_op_p0;
  logic [ACC_W-1:0] acc_p1;
  logic             ovf_p1;
  logic [CNT_W-1:0] cnt_p1;
  logic [ACC_W:0]   sum_w;

  // Unsigned accumulate; the extra MSB is the carry-out of the add.
  function automatic logic [ACC_W:0] acc_add(input logic [ACC_W-1:0] a,
                                             input logic [7:0]       p);
    return {1'b0, a} + {{(ACC_W - 7){1'b0}}, p};
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state <= ACCEPT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_rdy    = 1'b0;
    out_vld   = 1'b0;
    case (state)
      ACCEPT: begin
        in_rdy = 1'b1;
        if (bus.in_valid) state_nxt = MUL;
      end
      MUL:     state_nxt = (cnt_p1 == LAST_TERM) ? DONE : ACCEPT;
      DONE: begin
        out_vld = 1'b1;
        if (bus.out_ready) state_nxt = ACCEPT;
      end
      default: state_nxt = ACCEPT;
    endcase
    // Handshakes are suppressed for the whole reset cycle.
    if (rst) begin
      in_rdy  = 1'b0;
      out_vld = 1'b0;
    end
  end

  assign sum_w = acc_add(acc_p1, mul_prod);

  // Stage p0: operand capture; stage p1: product accumulate and term count
  always_ff @(posedge clk) begin
    if (rst) begin
      mul_op_p0 <= 8'h00;
      acc_p1    <= '0;
      ovf_p1    <= 1'b0;
      cnt_p1    <= '0;
    end else begin
      case (state)
        ACCEPT: if (bus.in_valid) mul_op_p0 <= bus.in_data;
        MUL: begin
          acc_p1 <= sum_w[ACC_W-1:0];
          ovf_p1 <= ovf_p1 | sum_w[ACC_W];
          cnt_p1 <= cnt_p1 + CNT_W'(1);
        end
        DONE: if (bus.out_ready) begin
          acc_p1 <= '0;
          ovf_p1 <= 1'b0;
          cnt_p1 <= '0;
        end
        default: ;
      endcase
    end
  end

  assign mul_op        = mul_op_p0;
  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = out_vld;
  assign bus.out_acc   = acc_p1;
  assign bus.out_ovf   = ovf_p1;
  assign busy          = (state != ACCEPT) || (cnt_p1 != '0);

endmodule
